// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Purpose:
//   Parametrised, pipelined carry-lookahead adder/subtractor. Operands are cut
//   into GRP-bit lookahead groups. Each pipeline stage resolves GPS groups
//   (SW = GRP*GPS result bits) and registers its carry into the next stage.
//   The operand bits a stage has not yet consumed ride skew registers. The
//   result bits a stage has already produced ride deskew registers. As a
//   result, every bit of one operation reaches the output register in the
//   same cycle. Latency is STAGES = WIDTH/SW cycles, and throughput is one
//   operation per cycle. The pipeline advances globally. When the output is
//   held, every stage holds.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of GRP*GPS
//   GRP    bits per lookahead group (fully expanded G/P lookahead inside)
//   GPS    groups per pipeline stage
//
// Configuration macro:
//   ADD_SAT_EN  when defined, a signed overflow saturates out_sum to the
//               signed max/min and raises out_sat. When undefined, out_sum
//               wraps and out_sat is tied to 0.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle (= !out_valid | out_ready)
//   in_a       in   operand A [WIDTH]
//   in_b       in   operand B [WIDTH]
//   in_cin     in   carry-in (add) / borrow-in (sub)
//   in_sub     in   0: A+B+cin, 1: A-B-cin
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   out_sum    out  result [WIDTH]
//   out_cout   out  carry out of MSB (sub: 1 = no borrow)
//   out_ovf    out  signed overflow, C[WIDTH] ^ C[WIDTH-1]
//   out_sat    out  saturation applied
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_sat
);

    localparam int SW     = GRP * GPS;
    localparam int STAGES = WIDTH / SW;

    if ((WIDTH % SW) != 0 || STAGES < 1) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH (%0d) must be a positive multiple of GRP*GPS (%0d)",
               WIDTH, SW);
    end

    // Group carries C[1..GRP], each written as its own sum of products:
    // C[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]C[0].
    // No carry is chained through another carry inside the group.
    function automatic logic [GRP:0] grp_carries(input logic [GRP-1:0] g,
                                                 input logic [GRP-1:0] p,
                                                 input logic           c0);
        logic [GRP:0] c;
        logic         term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GRP; i++) begin
            term = c0;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_prep;
    logic             c0_prep;

    // The pipeline only stalls when a valid result is being held downstream.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign b_prep   = in_sub ? ~in_b : in_b;
    assign c0_prep  = in_sub ? ~in_cin : in_cin;

    // Stage word x: the bits below the stage's slice already hold sum bits.
    // The bits at and above the slice still hold operand A.
    logic [WIDTH-1:0]  x_reg [STAGES];
    logic [WIDTH-1:0]  x_nx  [STAGES];
    logic [STAGES-1:0] c_reg;
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] v_reg;
    logic              ovf_reg;
    logic              last_ovf;
    logic [WIDTH-1:0]  sum_fin;
`ifdef ADD_SAT_EN
    logic              last_sign;
    logic              sat_reg;
    logic              sat_nx;
`endif

    genvar gi;

    // Skew registers for B'. Each register holds only the B' bits that later
    // stages have not consumed yet, so the register shrinks by SW per stage.
    for (gi = 0; gi < STAGES - 1; gi++) begin : g_ypipe
        localparam int YW = WIDTH - SW * (gi + 1);
        logic [YW-1:0] y_in;
        logic [YW-1:0] y_reg;
        if (gi == 0) begin : g_src_in
            assign y_in = b_prep[WIDTH-1:SW];
        end else begin : g_src_prev
            assign y_in = g_ypipe[gi-1].y_reg[YW+SW-1:SW];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_reg <= '0;
            end else if (adv) begin
                y_reg <= y_in;
            end
        end
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] x_in;
        logic [SW-1:0]    b_s;
        logic             c_in;
        logic [SW-1:0]    s_s;
        logic             c_o;
        logic [WIDTH-1:0] x_o;
        logic [GRP:0]     cg;
        logic             c_run;

        if (gi == 0) begin : g_first
            assign x_in = in_a;
            assign b_s  = b_prep[SW-1:0];
            assign c_in = c0_prep;
        end else begin : g_next
            assign x_in = x_reg[gi-1];
            assign b_s  = g_ypipe[gi-1].y_reg[SW-1:0];
            assign c_in = c_reg[gi-1];
        end

        // Within a stage the groups are chained through their group carries.
        // Only the stage boundary is registered.
        always_comb begin
            c_run = c_in;
            s_s   = '0;
            cg    = '0;
            for (int g = 0; g < GPS; g++) begin
                cg = grp_carries(x_in[gi*SW + g*GRP +: GRP] & b_s[g*GRP +: GRP],
                                 x_in[gi*SW + g*GRP +: GRP] ^ b_s[g*GRP +: GRP],
                                 c_run);
                s_s[g*GRP +: GRP] = x_in[gi*SW + g*GRP +: GRP] ^ b_s[g*GRP +: GRP]
                                    ^ cg[GRP-1:0];
                c_run = cg[GRP];
            end
            c_o = c_run;
        end

        always_comb begin
            x_o = x_in;
            x_o[gi*SW +: SW] = s_s;
        end

        assign x_nx[gi] = x_o;
        assign c_nx[gi] = c_o;

        if (gi == STAGES - 1) begin : g_last
            // C[WIDTH-1] is recovered from the MSB sum bit as s ^ a ^ b'.
            assign last_ovf = c_o ^ s_s[SW-1] ^ x_in[WIDTH-1] ^ b_s[SW-1];
`ifdef ADD_SAT_EN
            // On overflow both operands share a sign, so A's MSB picks the rail.
            assign last_sign = x_in[WIDTH-1];
`endif
        end
    end

`ifdef ADD_SAT_EN
    always_comb begin
        sat_nx  = last_ovf;
        sum_fin = x_nx[STAGES-1];
        if (last_ovf) begin
            sum_fin = last_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_fin = x_nx[STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg   <= '0;
            c_reg   <= '0;
            ovf_reg <= 1'b0;
            for (int k = 0; k < STAGES; k++) x_reg[k] <= '0;
`ifdef ADD_SAT_EN
            sat_reg <= 1'b0;
`endif
        end else if (adv) begin
            v_reg[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) v_reg[k] <= v_reg[k-1];
            c_reg <= c_nx;
            for (int k = 0; k < STAGES - 1; k++) x_reg[k] <= x_nx[k];
            x_reg[STAGES-1] <= sum_fin;
            ovf_reg <= last_ovf;
`ifdef ADD_SAT_EN
            sat_reg <= sat_nx;
`endif
        end
    end

    assign out_valid = v_reg[STAGES-1];
    assign out_sum   = x_reg[STAGES-1];
    assign out_cout  = c_reg[STAGES-1];
    assign out_ovf   = ovf_reg;
`ifdef ADD_SAT_EN
    assign out_sat   = sat_reg;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_sat;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GRP(4), .GPS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_sat  (out_sat)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         sat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;
    bit   last_fire = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the true mathematical result.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input int acc);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint c  = cin ? 64'sd1 : 64'sd0;
        longint tu;
        longint ts;
        if (!sub) begin
            tu = ua + ub + c;
            ts = sa + sb + c;
            e.cout = (tu >= 65536);
        end else begin
            tu = ua - ub - c;
            ts = sa - sb - c;
            e.cout = (tu >= 0);
        end
        e.sum = tu[W-1:0];
        e.ovf = (ts > 32767) || (ts < -32768);
        e.sat = 1'b0;
`ifdef ADD_SAT_EN
        if (e.ovf) begin
            e.sum = (ts > 0) ? 16'h7FFF : 16'h8000;
            e.sat = 1'b1;
        end
`endif
        e.acc = acc;
        return e;
    endfunction

    // One clock cycle: check outputs at the negedge, record handshakes,
    // then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("sum", {16'd0, out_sum}, {16'd0, q[0].sum});
                chk("cout", {31'd0, out_cout}, {31'd0, q[0].cout});
                chk("ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
                chk("sat", {31'd0, out_sat}, {31'd0, q[0].sat});
                if (chk_lat && out_ready) chk("latency", cyc - q[0].acc, 32'd2);
                if (out_ready) void'(q.pop_front());
            end
        end
        last_fire = rst_n && in_valid && in_ready;
        if (last_fire) q.push_back(model(in_a, in_b, in_cin, in_sub, cyc));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        drive(a, b, cin, sub);
        last_fire = 1'b0;
        for (int i = 0; i < 20 && !last_fire; i++) tick();
        chk("accept", {31'd0, last_fire}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 32'd0);
        tick();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
        chk("rst_cout", {31'd0, out_cout}, 32'd0);
        chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_sat", {31'd0, out_sat}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Carry through every group, and exact latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain();

        // Subtraction, borrow, and the saturation cases.
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();
        send(16'h0000, 16'h0001, 1'b0, 1'b1);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();
        send(16'h1234, 16'h1233, 1'b1, 1'b1);
        drain();

        // Back-to-back stream at full rate.
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        drain();

        // Fill the pipeline with the output blocked, then release it.
        chk_lat = 1'b0;
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h0F0F, 16'h0001, 1'b1, 1'b0);
        drive(16'h5000, 16'h4000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        last_fire = 1'b0;
        for (int i = 0; i < 20 && !last_fire; i++) tick();
        chk("stall_accept", {31'd0, last_fire}, 32'd1);
        drain();
        chk_lat = 1'b1;

        // Reset in mid-stream discards everything in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        send(16'h0003, 16'h0004, 1'b0, 1'b0);
        drain();

        // Random traffic with random back-pressure.
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            in_sub    = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
